// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types: machine word and memory write byte mask.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  localparam lc3b_mem_wmask WMASK_ALL = 2'b11;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (A: instruction read, B: data read/write) responder sharing one
// physical memory port; alternates on ties and returns single-cycle responses.
module mem_arbiter
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_read_a,
  input  lc3b_word      mem_address_a,
  output lc3b_word      mem_rdata_a,
  output logic          mem_resp_a,
  input  logic          mem_read_b,
  input  logic          mem_write_b,
  input  lc3b_mem_wmask mem_byte_enable_b,
  input  lc3b_word      mem_address_b,
  input  lc3b_word      mem_wdata_b,
  output lc3b_word      mem_rdata_b,
  output logic          mem_resp_b,
  output logic          pmem_read,
  output logic          pmem_write,
  output lc3b_word      pmem_address,
  output lc3b_word      pmem_wdata,
  output lc3b_mem_wmask pmem_byte_enable,
  input  lc3b_word      pmem_rdata,
  input  logic          pmem_resp
);

  typedef enum logic [2:0] {IDLE, SERVE_A, SERVE_B, DONE_A, DONE_B} state_e;

  state_e        r_state;
  logic          r_last_b;
  lc3b_word      r_addr, r_wdata, r_rdata_a, r_rdata_b;
  lc3b_mem_wmask r_be;
  logic          r_pmem_read, r_pmem_write, r_resp_a, r_resp_b;

  logic w_req_b, w_grant_a, w_grant_b;

  // On a tie, B wins unless it was the last port granted.
  assign w_req_b   = mem_read_b | mem_write_b;
  assign w_grant_b = w_req_b & (~mem_read_a | ~r_last_b);
  assign w_grant_a = mem_read_a & ~w_grant_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_b     <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_be         <= WMASK_ALL;
      r_rdata_a    <= '0;
      r_rdata_b    <= '0;
      r_pmem_read  <= 1'b0;
      r_pmem_write <= 1'b0;
      r_resp_a     <= 1'b0;
      r_resp_b     <= 1'b0;
    end else begin
      r_resp_a <= 1'b0;
      r_resp_b <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_b) begin
            r_state      <= SERVE_B;
            r_last_b     <= 1'b1;
            r_addr       <= mem_address_b;
            r_wdata      <= mem_wdata_b;
            r_be         <= mem_write_b ? mem_byte_enable_b : WMASK_ALL;
            r_pmem_write <= mem_write_b;
            r_pmem_read  <= ~mem_write_b;
          end else if (w_grant_a) begin
            r_state      <= SERVE_A;
            r_last_b     <= 1'b0;
            r_addr       <= mem_address_a;
            r_be         <= WMASK_ALL;
            r_pmem_write <= 1'b0;
            r_pmem_read  <= 1'b1;
          end
        end
        // The physical access always completes; a withdrawn request only
        // suppresses the response and the rdata update.
        SERVE_A: begin
          if (pmem_resp) begin
            r_state     <= DONE_A;
            r_pmem_read <= 1'b0;
            if (mem_read_a) begin
              r_resp_a  <= 1'b1;
              r_rdata_a <= pmem_rdata;
            end
          end
        end
        SERVE_B: begin
          if (pmem_resp) begin
            r_state      <= DONE_B;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            if (w_req_b) begin
              r_resp_b <= 1'b1;
              if (r_pmem_read) r_rdata_b <= pmem_rdata;
            end
          end
        end
        DONE_A, DONE_B: r_state <= IDLE;
        default:        r_state <= IDLE;
      endcase
    end
  end

  assign mem_rdata_a      = r_rdata_a;
  assign mem_resp_a       = r_resp_a;
  assign mem_rdata_b      = r_rdata_b;
  assign mem_resp_b       = r_resp_b;
  assign pmem_read        = r_pmem_read;
  assign pmem_write       = r_pmem_write;
  assign pmem_address     = r_addr;
  assign pmem_wdata       = r_wdata;
  assign pmem_byte_enable = r_be;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural memory responder, response scoreboard,
// a vector table of single transactions and hand sequences for corner cases.
module tb_mem_arbiter;
  import lc3b_types::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_read_a = 1'b0;
  lc3b_word      mem_address_a = '0;
  lc3b_word      mem_rdata_a;
  logic          mem_resp_a;
  logic          mem_read_b = 1'b0;
  logic          mem_write_b = 1'b0;
  lc3b_mem_wmask mem_byte_enable_b = '0;
  lc3b_word      mem_address_b = '0;
  lc3b_word      mem_wdata_b = '0;
  lc3b_word      mem_rdata_b;
  logic          mem_resp_b;
  logic          pmem_read, pmem_write;
  lc3b_word      pmem_address, pmem_wdata;
  lc3b_mem_wmask pmem_byte_enable;
  lc3b_word      pmem_rdata = '0;
  logic          pmem_resp = 1'b0;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read_a(mem_read_a), .mem_address_a(mem_address_a),
    .mem_rdata_a(mem_rdata_a), .mem_resp_a(mem_resp_a),
    .mem_read_b(mem_read_b), .mem_write_b(mem_write_b),
    .mem_byte_enable_b(mem_byte_enable_b), .mem_address_b(mem_address_b),
    .mem_wdata_b(mem_wdata_b), .mem_rdata_b(mem_rdata_b), .mem_resp_b(mem_resp_b),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_byte_enable(pmem_byte_enable),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  // Memory model: unwritten words read as ~addr, except 0x1000 which holds 0xBEEF.
  lc3b_word tmem [lc3b_word];
  bit       auto_en = 1'b1;
  int       lat = 1;
  int       cnt = 0;
  int       pulse_req = 0;
  int       pulse_done = 0;

  function automatic lc3b_word mrd(input lc3b_word a);
    if (tmem.exists(a)) return tmem[a];
    return (a == 16'h1000) ? 16'hBEEF : ~a;
  endfunction

  always @(negedge clk) begin : responder
    lc3b_word v;
    if (pmem_resp) begin
      pmem_resp = 1'b0;
      cnt = 0;
    end else if (pulse_req != pulse_done) begin
      pulse_done = pulse_req;
      pmem_resp  = 1'b1;
      pmem_rdata = 16'hDEAD;
    end else if (auto_en && rst_n && (pmem_read || pmem_write)) begin
      cnt++;
      if (cnt >= lat) begin
        pmem_resp = 1'b1;
        if (pmem_write) begin
          v = mrd(pmem_address);
          if (pmem_byte_enable[0]) v[7:0]  = pmem_wdata[7:0];
          if (pmem_byte_enable[1]) v[15:8] = pmem_wdata[15:8];
          tmem[pmem_address] = v;
        end else begin
          pmem_rdata = mrd(pmem_address);
        end
      end
    end
  end

  typedef struct {
    bit       port_b;
    bit       chk_data;
    lc3b_word data;
  } exp_t;

  typedef struct {
    bit            rd_a, rd_b, wr_b;
    lc3b_word      addr, wdata;
    lc3b_mem_wmask be;
    int            lat;
    lc3b_mem_wmask exp_be;
    bit            exp_wr;
    lc3b_word      exp_data;
  } vec_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event did not occur as required (cycle %0d)", name, cyc);
  endtask

  task automatic push(input bit pb, input bit cd, input lc3b_word d);
    exp_t e;
    e.port_b = pb; e.chk_data = cd; e.data = d;
    sbq.push_back(e);
  endtask

  // Advance one cycle, sample 1 time unit after the edge and retire responses.
  task automatic tick();
    exp_t e;
    @(posedge clk); #1;
    cyc++;
    if (mem_resp_a || mem_resp_b) begin
      if (sbq.size() == 0) fail_now("unexpected_resp");
      else begin
        e = sbq.pop_front();
        chk("resp_port_b", 32'(mem_resp_b), 32'(e.port_b));
        chk("resp_single", 32'(mem_resp_a & mem_resp_b), 32'd0);
        if (e.chk_data)
          chk("resp_rdata", 32'(e.port_b ? mem_rdata_b : mem_rdata_a), 32'(e.data));
      end
    end
  endtask

  task automatic drop_all();
    mem_read_a = 1'b0; mem_read_b = 1'b0; mem_write_b = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    bit seen;
    mem_read_a = v.rd_a; mem_address_a = v.addr;
    mem_read_b = v.rd_b; mem_write_b = v.wr_b;
    mem_address_b = v.addr; mem_wdata_b = v.wdata; mem_byte_enable_b = v.be;
    lat = v.lat;
    push(!v.rd_a, !v.exp_wr, v.exp_data);
    tick();
    chk("vec_pmem_read",  32'(pmem_read),        32'(!v.exp_wr));
    chk("vec_pmem_write", 32'(pmem_write),       32'(v.exp_wr));
    chk("vec_pmem_addr",  32'(pmem_address),     32'(v.addr));
    chk("vec_pmem_be",    32'(pmem_byte_enable), 32'(v.exp_be));
    if (v.exp_wr) chk("vec_pmem_wdata", 32'(pmem_wdata), 32'(v.wdata));
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      seen = v.rd_a ? mem_resp_a : mem_resp_b;
    end
    if (!seen) fail_now("vec_resp_timeout");
    drop_all();
    tick();
    tick();
  endtask

  function automatic vec_t mk(input bit ra, rb, wb, input lc3b_word a, wd,
                              input lc3b_mem_wmask be, input int l,
                              input lc3b_mem_wmask ebe, input bit ew, input lc3b_word ed);
    vec_t v;
    v.rd_a = ra; v.rd_b = rb; v.wr_b = wb; v.addr = a; v.wdata = wd; v.be = be;
    v.lat = l; v.exp_be = ebe; v.exp_wr = ew; v.exp_data = ed;
    return v;
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t tv[8];
    int   c0, got, nw;
    int   rc[4];
    bit   done_a;

    tv[0] = mk(1, 0, 0, 16'hFFFF, 16'h0000, 2'b00, 5, 2'b11, 0, 16'h0000);
    tv[1] = mk(0, 1, 0, 16'h0080, 16'h0000, 2'b01, 1, 2'b11, 0, 16'hFF7F);
    tv[2] = mk(0, 0, 1, 16'h0100, 16'hA5C3, 2'b01, 3, 2'b01, 1, 16'h0000);
    tv[3] = mk(0, 1, 0, 16'h0100, 16'h0000, 2'b11, 1, 2'b11, 0, 16'hFEC3);
    tv[4] = mk(0, 1, 1, 16'h0200, 16'h7777, 2'b11, 1, 2'b11, 1, 16'h0000);
    tv[5] = mk(0, 1, 0, 16'h0200, 16'h0000, 2'b11, 2, 2'b11, 0, 16'h7777);
    tv[6] = mk(0, 1, 0, 16'h3002, 16'h0000, 2'b11, 1, 2'b11, 0, 16'h12FD);
    tv[7] = mk(1, 0, 0, 16'h0040, 16'h0000, 2'b00, 2, 2'b11, 0, 16'hFFBF);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pmem_read",  32'(pmem_read), 32'd0);
    chk("rst_pmem_write", 32'(pmem_write), 32'd0);
    chk("rst_resp_a",     32'(mem_resp_a), 32'd0);
    chk("rst_resp_b",     32'(mem_resp_b), 32'd0);
    chk("rst_pmem_addr",  32'(pmem_address), 32'd0);
    chk("rst_pmem_wdata", 32'(pmem_wdata), 32'd0);
    chk("rst_rdata_a",    32'(mem_rdata_a), 32'd0);
    chk("rst_rdata_b",    32'(mem_rdata_b), 32'd0);
    rst_n = 1'b1;
    tick(); tick();

    // Lone A read, memory answers in cycle 3
    mem_read_a = 1'b1; mem_address_a = 16'h1000; lat = 3;
    push(0, 1, 16'hBEEF);
    chk("t1_c0_pread", 32'(pmem_read), 32'd0);
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk("t1_pread", 32'(pmem_read), 32'(c <= 3));
      chk("t1_resp_a", 32'(mem_resp_a), 32'(c == 4));
      if (c <= 3) chk("t1_paddr", 32'(pmem_address), 32'h1000);
      if (c == 4) begin
        chk("t1_rdata_a", 32'(mem_rdata_a), 32'hBEEF);
        mem_read_a = 1'b0;
      end
    end

    // Tie from reset, both held: B, A, B, A at cycles 2, 5, 8, 11
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    lat = 1;
    mem_read_a = 1'b1; mem_address_a = 16'h1100;
    mem_read_b = 1'b1; mem_address_b = 16'h2000;
    push(1, 1, 16'hDFFF); push(0, 1, 16'hEEFF);
    push(1, 1, 16'hDFFF); push(0, 1, 16'hEEFF);
    c0 = cyc; got = 0;
    for (int i = 0; i < 40 && got < 4; i++) begin
      tick();
      if (mem_resp_a || mem_resp_b) begin
        rc[got] = cyc - c0;
        got++;
      end
    end
    drop_all();
    chk("t2_resp_count", 32'(got), 32'd4);
    for (int i = 0; i < 4 && i < got; i++) chk("t2_resp_cycle", 32'(rc[i]), 32'(2 + 3 * i));
    tick(); tick();

    // B write with A pending: B wins the tie, A's address never leaks
    mem_read_a = 1'b1; mem_address_a = 16'h1200;
    mem_write_b = 1'b1; mem_address_b = 16'h3002;
    mem_wdata_b = 16'h1234; mem_byte_enable_b = 2'b10; lat = 2;
    push(1, 0, 16'h0000); push(0, 1, 16'hEDFF);
    nw = 0; done_a = 1'b0;
    for (int i = 0; i < 30 && !done_a; i++) begin
      tick();
      if (pmem_write) begin
        nw++;
        chk("t3_wdata", 32'(pmem_wdata), 32'h1234);
        chk("t3_be",    32'(pmem_byte_enable), 32'h2);
        chk("t3_addr",  32'(pmem_address), 32'h3002);
      end
      if (mem_resp_b) mem_write_b = 1'b0;
      if (mem_resp_a) begin
        mem_read_a = 1'b0;
        done_a = 1'b1;
      end
    end
    if (!done_a) fail_now("t3_resp_a_timeout");
    chk("t3_write_cycles", 32'(nw), 32'd2);
    drop_all();
    tick(); tick();

    // Vector table
    for (int i = 0; i < 8; i++) run_vec(tv[i]);

    // A read withdrawn during SERVE_A
    mem_read_a = 1'b1; mem_address_a = 16'h1400; lat = 4;
    tick();
    chk("t4_pread", 32'(pmem_read), 32'd1);
    tick();
    mem_read_a = 1'b0;
    begin
      bit fell;
      fell = 1'b0;
      for (int i = 0; i < 20 && !fell; i++) begin
        tick();
        fell = !pmem_read;
      end
      if (!fell) fail_now("t4_pread_fall");
    end
    chk("t4_resp_a", 32'(mem_resp_a), 32'd0);
    chk("t4_rdata_a", 32'(mem_rdata_a), 32'hFFBF);
    tick();
    chk("t4_resp_a_after", 32'(mem_resp_a), 32'd0);
    chk("t4_rdata_a_after", 32'(mem_rdata_a), 32'hFFBF);
    run_vec(mk(1, 0, 0, 16'h1500, 16'h0000, 2'b00, 1, 2'b11, 0, 16'hEAFF));

    // Reset during SERVE_B, stray pmem_resp after release
    auto_en = 1'b0;
    mem_read_b = 1'b1; mem_address_b = 16'h2200;
    tick();
    chk("t5_pread", 32'(pmem_read), 32'd1);
    chk("t5_paddr", 32'(pmem_address), 32'h2200);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t5_rst_pread",  32'(pmem_read), 32'd0);
    chk("t5_rst_pwrite", 32'(pmem_write), 32'd0);
    chk("t5_rst_paddr",  32'(pmem_address), 32'd0);
    chk("t5_rst_resp_b", 32'(mem_resp_b), 32'd0);
    chk("t5_rst_rdata_b", 32'(mem_rdata_b), 32'd0);
    chk("t5_rst_rdata_a", 32'(mem_rdata_a), 32'd0);
    mem_read_b = 1'b0;
    tick();
    rst_n = 1'b1;
    pulse_req++;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_no_resp_b", 32'(mem_resp_b), 32'd0);
      chk("t5_idle_pread", 32'(pmem_read), 32'd0);
    end
    auto_en = 1'b1;
    run_vec(mk(0, 1, 0, 16'h0080, 16'h0000, 2'b11, 1, 2'b11, 0, 16'hFF7F));

    // Back-to-back A reads, 1-cycle memory: responses at cycles 2, 5, 8
    lat = 1;
    for (int c = 0; c <= 9; c++) begin
      if (c >= 1) begin
        chk("t6_resp_a", 32'(mem_resp_a), 32'(c == 2 || c == 5 || c == 8));
        chk("t6_paddr", 32'(pmem_address),
            (c <= 3) ? 32'h1600 : (c <= 6) ? 32'h1606 : 32'h160C);
      end
      if (c == 8) mem_read_a = 1'b0;
      mem_address_a = 16'h1600 + 16'(2 * c);
      if (c == 0) mem_read_a = 1'b1;
      if (c == 0) push(0, 1, 16'hE9FF);
      if (c == 3) push(0, 1, 16'hE9F9);
      if (c == 6) push(0, 1, 16'hE9F3);
      tick();
    end
    tick(); tick();

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
